// File: rtl/picosoc_a2_eventq.sv
// -----------------------------------------------------------------------------
// picosoc_a2_eventq
//
// Event queue that sits between a PicoSoC memory-mapped bus and two event
// sources: a keyboard (keycodes) and the Apple II bus (writes to a single
// command address). Each source feeds its own FIFO. The PicoSoC pops entries,
// inspects status, clears sticky overflow flags, flushes the queues and
// enables a level interrupt through five registers decoded from addr[4:2].
//
// Ports:
//   clk, resetn                single clock, asynchronous active-low reset
//   iomem_valid/wstrb/addr/wdata  PicoSoC bus request (wstrb != 0 means write)
//   iomem_rdata, iomem_ready   registered read data and one-cycle completion
//   key_strobe, key_code       one-cycle keypress event and its keycode
//   a2_wr_strobe, a2_addr, a2_data  Apple II bus write cycle
//   irq                        registered level interrupt
//
// Register map (addr[4:2]):
//   0 KEY_DATA  R    {23'b0, valid, code}, pops when non-empty
//   1 CMD_DATA  R    {23'b0, valid, data}, pops when non-empty
//   2 STATUS    R/W1C  [0] key ne, [1] cmd ne, [2] key ovf, [3] cmd ovf,
//                      [15:8] key count, [23:16] cmd count
//   3 IRQ_EN    R/W  [0] key ne, [1] cmd ne, [2] overflow
//   4 FLUSH     W    [0] empty key FIFO, [1] empty cmd FIFO; reads 0
// -----------------------------------------------------------------------------

// Byte-wide FIFO used for both event queues. The overflow output flags a push
// that was refused because the FIFO was full and nothing left this cycle.
module picosoc_a2_eventq_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      push,
    input  logic [7:0]                push_data,
    input  logic                      pop_req,
    input  logic                      flush,
    output logic [7:0]                head,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      not_empty,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          push_ok;

    assign not_empty = (count != '0);
    assign full      = (count == FULL_COUNT);
    assign head      = mem[rd_ptr];

    // Flush dominates everything. A pop frees a slot in the same cycle, so a
    // push into a full FIFO is still accepted when it coincides with a pop.
    assign pop      = pop_req & not_empty & ~flush;
    assign push_ok  = push & ~flush & (~full | pop);
    assign overflow = push & ~flush & full & ~pop;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

module picosoc_a2_eventq #(
    parameter int          KEY_DEPTH = 16,
    parameter int          CMD_DEPTH = 16,
    parameter logic [15:0] CMD_ADDR  = 16'hC7FF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        iomem_ready,
    input  logic        key_strobe,
    input  logic [7:0]  key_code,
    input  logic        a2_wr_strobe,
    input  logic [15:0] a2_addr,
    input  logic [7:0]  a2_data,
    output logic        irq
);

    localparam logic [2:0] REG_KEY_DATA = 3'd0;
    localparam logic [2:0] REG_CMD_DATA = 3'd1;
    localparam logic [2:0] REG_STATUS   = 3'd2;
    localparam logic [2:0] REG_IRQ_EN   = 3'd3;
    localparam logic [2:0] REG_FLUSH    = 3'd4;

    logic        req_accept;
    logic        rd_accept;
    logic        wr_accept;
    logic [2:0]  reg_sel;

    logic        key_pop_req;
    logic        cmd_pop_req;
    logic        key_flush;
    logic        cmd_flush;
    logic        cmd_push;
    logic        clr_key_ovf;
    logic        clr_cmd_ovf;
    logic        irq_en_wr;

    logic [7:0]  key_head;
    logic [7:0]  cmd_head;
    logic [$clog2(KEY_DEPTH):0] key_count;
    logic [$clog2(CMD_DEPTH):0] cmd_count;
    logic        key_ne;
    logic        cmd_ne;
    logic        key_overflow;
    logic        cmd_overflow;

    logic        key_ovf;
    logic        cmd_ovf;
    logic [2:0]  irq_en;
    logic        irq_next;
    logic [31:0] rdata_next;
    logic [31:0] status_word;

    // Address and data bits that the register map never looks at.
    logic        unused_bits;
    assign unused_bits = &{1'b0, iomem_addr[31:5], iomem_addr[1:0], iomem_wdata[31:4]};

    // A request is taken only while ready is low, so a master that keeps
    // valid high through the ready cycle still gets a single completion.
    assign req_accept = iomem_valid & ~iomem_ready;
    assign rd_accept  = req_accept & ~(|iomem_wstrb);
    assign wr_accept  = req_accept & (|iomem_wstrb);
    assign reg_sel    = iomem_addr[4:2];

    assign key_pop_req = rd_accept & (reg_sel == REG_KEY_DATA);
    assign cmd_pop_req = rd_accept & (reg_sel == REG_CMD_DATA);
    assign key_flush   = wr_accept & (reg_sel == REG_FLUSH) & iomem_wdata[0];
    assign cmd_flush   = wr_accept & (reg_sel == REG_FLUSH) & iomem_wdata[1];
    assign clr_key_ovf = wr_accept & (reg_sel == REG_STATUS) & iomem_wdata[2];
    assign clr_cmd_ovf = wr_accept & (reg_sel == REG_STATUS) & iomem_wdata[3];
    assign irq_en_wr   = wr_accept & (reg_sel == REG_IRQ_EN);
    assign cmd_push    = a2_wr_strobe & (a2_addr == CMD_ADDR);

    picosoc_a2_eventq_fifo #(.DEPTH(KEY_DEPTH)) u_key_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (key_strobe),
        .push_data (key_code),
        .pop_req   (key_pop_req),
        .flush     (key_flush),
        .head      (key_head),
        .count     (key_count),
        .not_empty (key_ne),
        .overflow  (key_overflow)
    );

    picosoc_a2_eventq_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (cmd_push),
        .push_data (a2_data),
        .pop_req   (cmd_pop_req),
        .flush     (cmd_flush),
        .head      (cmd_head),
        .count     (cmd_count),
        .not_empty (cmd_ne),
        .overflow  (cmd_overflow)
    );

    assign status_word = {8'b0, 8'(cmd_count), 8'(key_count),
                          4'b0, cmd_ovf, key_ovf, cmd_ne, key_ne};

    // Read data is formed from the state seen in the accept cycle, so a
    // coincident push is not visible to the read that pops in that cycle.
    always_comb begin
        rdata_next = 32'b0;
        if (rd_accept) begin
            case (reg_sel)
                REG_KEY_DATA: if (key_ne) rdata_next = {23'b0, 1'b1, key_head};
                REG_CMD_DATA: if (cmd_ne) rdata_next = {23'b0, 1'b1, cmd_head};
                REG_STATUS:   rdata_next = status_word;
                REG_IRQ_EN:   rdata_next = {29'b0, irq_en};
                default:      rdata_next = 32'b0;
            endcase
        end
    end

    assign irq_next = (irq_en[0] & key_ne) | (irq_en[1] & cmd_ne) |
                      (irq_en[2] & (key_ovf | cmd_ovf));

    // Overflow set takes priority over a write-one-to-clear in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'b0;
            irq         <= 1'b0;
            irq_en      <= 3'b0;
            key_ovf     <= 1'b0;
            cmd_ovf     <= 1'b0;
        end else begin
            iomem_ready <= req_accept;
            iomem_rdata <= rdata_next;
            irq         <= irq_next;
            if (irq_en_wr) begin
                irq_en <= iomem_wdata[2:0];
            end
            key_ovf <= key_overflow | (key_ovf & ~clr_key_ovf);
            cmd_ovf <= cmd_overflow | (cmd_ovf & ~clr_cmd_ovf);
        end
    end

endmodule

// File: tb/tb_picosoc_a2_eventq.sv
// -----------------------------------------------------------------------------
// tb_picosoc_a2_eventq
//
// Self-checking bench for picosoc_a2_eventq with default parameters.
// Directed table of bus/strobe operations with expected read values, hand
// sequences for coincident push/pop/flush/clear and reset corner cases, then
// a randomized run compared cycle by cycle against a queue-based model.
// -----------------------------------------------------------------------------
module tb_picosoc_a2_eventq;

    localparam int          DEPTH    = 16;
    localparam logic [15:0] CMD_ADDR = 16'hC7FF;

    logic        clk;
    logic        resetn;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        iomem_ready;
    logic        key_strobe;
    logic [7:0]  key_code;
    logic        a2_wr_strobe;
    logic [15:0] a2_addr;
    logic [7:0]  a2_data;
    logic        irq;

    int checks = 0;
    int errors = 0;

    picosoc_a2_eventq dut (
        .clk          (clk),
        .resetn       (resetn),
        .iomem_valid  (iomem_valid),
        .iomem_wstrb  (iomem_wstrb),
        .iomem_addr   (iomem_addr),
        .iomem_wdata  (iomem_wdata),
        .iomem_rdata  (iomem_rdata),
        .iomem_ready  (iomem_ready),
        .key_strobe   (key_strobe),
        .key_code     (key_code),
        .a2_wr_strobe (a2_wr_strobe),
        .a2_addr      (a2_addr),
        .a2_data      (a2_data),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {OP_KEY, OP_A2, OP_RD, OP_WR} op_e;

    typedef struct {
        op_e         kind;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] expect_val;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(op_e k, logic [15:0] a, logic [31:0] d,
                                   logic [31:0] e, string n);
        vec_t v;
        v.kind = k; v.addr = a; v.data = d; v.expect_val = e; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // All driving happens at negedges; ops return on a negedge.
    task automatic keyPush(input logic [7:0] code);
        key_strobe = 1'b1;
        key_code   = code;
        @(negedge clk);
        key_strobe = 1'b0;
    endtask

    task automatic a2Write(input logic [15:0] addr, input logic [7:0] data);
        a2_wr_strobe = 1'b1;
        a2_addr      = addr;
        a2_data      = data;
        @(negedge clk);
        a2_wr_strobe = 1'b0;
    endtask

    // Bus request with optional strobes that coincide with the accept cycle.
    // Returns at the negedge of the ready cycle with valid already dropped.
    task automatic busOp(input logic wr, input logic [2:0] sel, input logic [31:0] wdata,
                         input logic ks, input logic [7:0] kc,
                         input logic as, input logic [15:0] aa, input logic [7:0] ad,
                         output logic [31:0] rdata);
        int waited;
        if (iomem_ready) @(negedge clk);
        iomem_valid  = 1'b1;
        iomem_wstrb  = wr ? 4'hF : 4'h0;
        iomem_addr   = {27'b0, sel, 2'b00};
        iomem_wdata  = wdata;
        key_strobe   = ks;
        key_code     = kc;
        a2_wr_strobe = as;
        a2_addr      = aa;
        a2_data      = ad;
        @(negedge clk);
        key_strobe   = 1'b0;
        a2_wr_strobe = 1'b0;
        waited = 0;
        while (!iomem_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready pulse", {31'b0, iomem_ready}, 32'd1);
        rdata       = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic rdReg(input logic [2:0] sel, output logic [31:0] rdata);
        busOp(1'b0, sel, 32'b0, 1'b0, 8'h0, 1'b0, 16'h0, 8'h0, rdata);
    endtask

    task automatic wrReg(input logic [2:0] sel, input logic [31:0] wdata);
        logic [31:0] dummy;
        busOp(1'b1, sel, wdata, 1'b0, 8'h0, 1'b0, 16'h0, 8'h0, dummy);
    endtask

    task automatic applyStimulus(input vec_t v, output logic [31:0] rdata);
        rdata = 32'b0;
        case (v.kind)
            OP_KEY:  keyPush(v.data[7:0]);
            OP_A2:   a2Write(v.addr, v.data[7:0]);
            OP_RD:   rdReg(v.addr[2:0], rdata);
            default: wrReg(v.addr[2:0], v.data);
        endcase
    endtask

    task automatic doReset();
        iomem_valid  = 1'b0;
        iomem_wstrb  = 4'h0;
        key_strobe   = 1'b0;
        a2_wr_strobe = 1'b0;
        resetn       = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Reference model state for the randomized run.
    logic [7:0]  keyq[$];
    logic [7:0]  cmdq[$];
    logic        m_key_ovf, m_cmd_ovf;
    logic [2:0]  m_irq_en;
    logic        exp_ready, exp_irq;
    logic [31:0] exp_rdata;

    initial begin
        logic [31:0] got;

        resetn       = 1'b0;
        iomem_valid  = 1'b0;
        iomem_wstrb  = 4'h0;
        iomem_addr   = 32'h0;
        iomem_wdata  = 32'h0;
        key_strobe   = 1'b0;
        key_code     = 8'h0;
        a2_wr_strobe = 1'b0;
        a2_addr      = 16'h0;
        a2_data      = 8'h0;

        // Directed table.
        addVec(OP_KEY, 0, 32'h41, 0, "");
        addVec(OP_KEY, 0, 32'h42, 0, "");
        addVec(OP_RD,  0, 0, 32'h141, "key read 1");
        addVec(OP_RD,  0, 0, 32'h142, "key read 2");
        addVec(OP_RD,  0, 0, 32'h000, "key read empty");
        addVec(OP_RD,  2, 0, 32'h0,   "status after drain");
        addVec(OP_A2,  16'hC7FF, 32'h55, 0, "");
        addVec(OP_A2,  16'hC7FE, 32'h66, 0, "");
        addVec(OP_RD,  1, 0, 32'h155, "cmd read");
        addVec(OP_RD,  1, 0, 32'h000, "cmd wrong addr ignored");
        addVec(OP_WR,  3, 32'h7, 0, "");
        addVec(OP_RD,  3, 0, 32'h7, "irq_en readback");
        addVec(OP_WR,  3, 32'hFFFFFFF8, 0, "");
        addVec(OP_RD,  3, 0, 32'h0, "irq_en upper bits ignored");
        addVec(OP_RD,  5, 0, 32'h0, "unmapped read 5");
        addVec(OP_RD,  4, 0, 32'h0, "flush reads zero");
        addVec(OP_RD,  7, 0, 32'h0, "unmapped read 7");
        addVec(OP_KEY, 0, 32'h10, 0, "");
        addVec(OP_KEY, 0, 32'h20, 0, "");
        addVec(OP_A2,  16'hC7FF, 32'h77, 0, "");
        addVec(OP_RD,  2, 0, 32'h00010203, "status counts");
        addVec(OP_WR,  4, 32'h1, 0, "");
        addVec(OP_RD,  2, 0, 32'h00010002, "status after key flush");
        addVec(OP_RD,  0, 0, 32'h0, "key read after flush");
        addVec(OP_RD,  1, 0, 32'h177, "cmd survives key flush");
        addVec(OP_KEY, 0, 32'h7E, 0, "");
        addVec(OP_WR,  6, 32'hFFFFFFFF, 0, "");
        addVec(OP_WR,  7, 32'hFFFFFFFF, 0, "");
        addVec(OP_WR,  2, 32'hFFFFFFF3, 0, "");
        addVec(OP_RD,  2, 0, 32'h00000101, "unmapped writes ignored");
        addVec(OP_RD,  0, 0, 32'h17E, "key after ignored writes");

        repeat (3) @(negedge clk);
        checkOutput("reset ready", {31'b0, iomem_ready}, 32'd0);
        checkOutput("reset rdata", iomem_rdata, 32'd0);
        checkOutput("reset irq", {31'b0, irq}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        rdReg(3'd2, got); checkOutput("reset status", got, 32'h0);
        rdReg(3'd3, got); checkOutput("reset irq_en", got, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], got);
            if (vecs[i].kind == OP_RD) checkOutput(vecs[i].name, got, vecs[i].expect_val);
        end

        // Overflow with 17 keys, W1C, then ordered drain.
        for (int i = 1; i <= 17; i++) keyPush(8'(i));
        rdReg(3'd2, got); checkOutput("ovf status", got, 32'h00001005);
        wrReg(3'd2, 32'h4);
        rdReg(3'd2, got); checkOutput("ovf cleared", got, 32'h00001001);
        for (int i = 1; i <= 16; i++) begin
            rdReg(3'd0, got); checkOutput("ovf drain", got, 32'h100 | 32'(i));
        end
        rdReg(3'd0, got); checkOutput("ovf drain empty", got, 32'h0);

        // Full FIFO: push coincident with pop.
        for (int i = 0; i < 16; i++) keyPush(8'(8'h80 + i));
        busOp(1'b0, 3'd0, 32'h0, 1'b1, 8'hEE, 1'b0, 16'h0, 8'h0, got);
        checkOutput("full push+pop data", got, 32'h180);
        rdReg(3'd2, got); checkOutput("full push+pop status", got, 32'h00001001);
        for (int i = 1; i < 16; i++) begin
            rdReg(3'd0, got); checkOutput("full push+pop drain", got, 32'h180 + 32'(i));
        end
        rdReg(3'd0, got); checkOutput("new key last", got, 32'h1EE);
        rdReg(3'd0, got); checkOutput("empty after last", got, 32'h0);

        // Empty FIFO: push coincident with pop.
        busOp(1'b0, 3'd0, 32'h0, 1'b1, 8'h5A, 1'b0, 16'h0, 8'h0, got);
        checkOutput("empty push+pop data", got, 32'h0);
        rdReg(3'd2, got); checkOutput("empty push+pop status", got, 32'h00000101);
        rdReg(3'd0, got); checkOutput("empty push+pop key", got, 32'h15A);

        // Flush coincident with push.
        keyPush(8'h11);
        busOp(1'b1, 3'd4, 32'h1, 1'b1, 8'h22, 1'b0, 16'h0, 8'h0, got);
        a2Write(CMD_ADDR, 8'h33);
        busOp(1'b1, 3'd4, 32'h2, 1'b0, 8'h0, 1'b1, CMD_ADDR, 8'h44, got);
        rdReg(3'd2, got); checkOutput("flush beats push", got, 32'h0);

        // Overflow coincident with W1C, overflow irq, flush keeps ovf.
        wrReg(3'd3, 32'h4);
        for (int i = 0; i < 16; i++) keyPush(8'(i));
        busOp(1'b1, 3'd2, 32'h4, 1'b1, 8'h99, 1'b0, 16'h0, 8'h0, got);
        rdReg(3'd2, got); checkOutput("ovf set beats clear", got, 32'h00001005);
        checkOutput("ovf irq", {31'b0, irq}, 32'd1);
        wrReg(3'd4, 32'h1);
        rdReg(3'd2, got); checkOutput("flush keeps ovf", got, 32'h00000004);
        wrReg(3'd2, 32'h4);
        rdReg(3'd2, got); checkOutput("ovf cleared after flush", got, 32'h0);
        checkOutput("ovf irq cleared", {31'b0, irq}, 32'd0);

        // Key interrupt timing.
        wrReg(3'd3, 32'h1);
        @(negedge clk);
        keyPush(8'h61);
        checkOutput("irq one cycle after strobe", {31'b0, irq}, 32'd0);
        @(negedge clk);
        checkOutput("irq two cycles after strobe", {31'b0, irq}, 32'd1);
        rdReg(3'd0, got);
        checkOutput("irq key data", got, 32'h161);
        checkOutput("irq in ready cycle", {31'b0, irq}, 32'd1);
        @(negedge clk);
        checkOutput("irq after ready", {31'b0, irq}, 32'd0);
        wrReg(3'd3, 32'h0);

        // Valid held two cycles: a single completion and a single pop.
        keyPush(8'h31);
        keyPush(8'h32);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        @(negedge clk);
        checkOutput("held valid ready", {31'b0, iomem_ready}, 32'd1);
        checkOutput("held valid data", iomem_rdata, 32'h131);
        @(negedge clk);
        checkOutput("held valid no second ready", {31'b0, iomem_ready}, 32'd0);
        checkOutput("held valid rdata zero", iomem_rdata, 32'h0);
        iomem_valid = 1'b0;
        @(negedge clk);
        checkOutput("held valid idle", {31'b0, iomem_ready}, 32'd0);
        rdReg(3'd2, got); checkOutput("held valid one pop", got, 32'h00000101);
        rdReg(3'd0, got); checkOutput("held valid next key", got, 32'h132);

        // Reset in the middle of a request.
        keyPush(8'h70);
        iomem_valid = 1'b1;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async reset ready", {31'b0, iomem_ready}, 32'd0);
        checkOutput("async reset rdata", iomem_rdata, 32'h0);
        iomem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("no ready after reset", {31'b0, iomem_ready}, 32'd0);
        end
        rdReg(3'd2, got); checkOutput("reset cleared fifo", got, 32'h0);

        // Randomized run against a queue model.
        doReset();
        keyq.delete();
        cmdq.delete();
        m_key_ovf = 1'b0; m_cmd_ovf = 1'b0; m_irq_en = 3'b0;
        exp_ready = 1'b0; exp_irq = 1'b0; exp_rdata = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        acc, is_wr, nxt_irq;
            logic [2:0]  sel;
            logic [31:0] nxt_rdata, wd;
            int          push_pct;

            checkOutput("rnd ready", {31'b0, iomem_ready}, {31'b0, exp_ready});
            checkOutput("rnd rdata", iomem_rdata, exp_rdata);
            checkOutput("rnd irq", {31'b0, irq}, {31'b0, exp_irq});

            push_pct     = ((cyc / 400) % 2 == 0) ? 40 : 10;
            key_strobe   = ($urandom_range(99) < push_pct);
            key_code     = 8'($urandom);
            a2_wr_strobe = ($urandom_range(99) < push_pct);
            a2_addr      = ($urandom_range(3) != 0) ? CMD_ADDR : 16'($urandom);
            a2_data      = 8'($urandom);
            iomem_valid  = ($urandom_range(99) < 40);
            iomem_wstrb  = ($urandom_range(3) == 0) ? 4'($urandom_range(15, 1)) : 4'h0;
            sel          = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(1));
            iomem_addr   = {$urandom, 5'b0} | {27'b0, sel, 2'b00} | 32'($urandom_range(3));
            wd           = $urandom;
            if (sel == 3'd4 && $urandom_range(3) != 0) wd = wd & ~32'h3;
            iomem_wdata  = wd;

            acc     = iomem_valid && !exp_ready;
            is_wr   = (iomem_wstrb != 4'h0);
            nxt_irq = (m_irq_en[0] && keyq.size() != 0) || (m_irq_en[1] && cmdq.size() != 0) ||
                      (m_irq_en[2] && (m_key_ovf || m_cmd_ovf));
            nxt_rdata = 32'h0;
            if (acc && !is_wr) begin
                case (sel)
                    3'd0: if (keyq.size() != 0) nxt_rdata = {23'b0, 1'b1, keyq[0]};
                    3'd1: if (cmdq.size() != 0) nxt_rdata = {23'b0, 1'b1, cmdq[0]};
                    3'd2: nxt_rdata = {8'b0, 8'(cmdq.size()), 8'(keyq.size()), 4'b0,
                                       m_cmd_ovf, m_key_ovf, cmdq.size() != 0, keyq.size() != 0};
                    3'd3: nxt_rdata = {29'b0, m_irq_en};
                    default: nxt_rdata = 32'h0;
                endcase
            end

            if (acc && !is_wr && sel == 3'd0 && keyq.size() != 0) void'(keyq.pop_front());
            if (acc && !is_wr && sel == 3'd1 && cmdq.size() != 0) void'(cmdq.pop_front());
            if (acc && is_wr && sel == 3'd2 && wd[2]) m_key_ovf = 1'b0;
            if (acc && is_wr && sel == 3'd2 && wd[3]) m_cmd_ovf = 1'b0;
            if (acc && is_wr && sel == 3'd3) m_irq_en = wd[2:0];

            if (acc && is_wr && sel == 3'd4 && wd[0]) keyq.delete();
            else if (key_strobe) begin
                if (keyq.size() < DEPTH) keyq.push_back(key_code);
                else m_key_ovf = 1'b1;
            end
            if (acc && is_wr && sel == 3'd4 && wd[1]) cmdq.delete();
            else if (a2_wr_strobe && a2_addr == CMD_ADDR) begin
                if (cmdq.size() < DEPTH) cmdq.push_back(a2_data);
                else m_cmd_ovf = 1'b1;
            end

            exp_ready = acc;
            exp_rdata = nxt_rdata;
            exp_irq   = nxt_irq;
            @(negedge clk);
        end
        key_strobe   = 1'b0;
        a2_wr_strobe = 1'b0;
        iomem_valid  = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/picosoc_a2_eventq.md
PICOSOC_A2_EVENTQ -- requirements
Module: picosoc_a2_eventq

Interface
REQ-001 Parameter KEY_DEPTH, default 16: keycode FIFO depth in entries; SHALL be a power of two, 2..128.
REQ-002 Parameter CMD_DEPTH, default 16: Apple II command FIFO depth in entries; SHALL be a power of two, 2..128.
REQ-003 Parameter CMD_ADDR, default 16'hC7FF: Apple II bus address whose writes are captured as commands.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 resetn  in  1  reset, asynchronous assert, active-low.
REQ-006 iomem_valid  in  1  PicoSoC bus request.
REQ-007 iomem_wstrb  in  4  write strobes; any bit set = write, all zero = read.
REQ-008 iomem_addr  in  32  byte address; only [4:2] decoded.
REQ-009 iomem_wdata  in  32  write data.
REQ-010 iomem_rdata  out  32  read data, registered.
REQ-011 iomem_ready  out  1  one-cycle completion pulse, registered.
REQ-012 key_strobe  in  1  one-cycle keypress event.
REQ-013 key_code  in  8  keycode, valid with key_strobe.
REQ-014 a2_wr_strobe  in  1  one-cycle Apple II bus write data-valid strobe.
REQ-015 a2_addr  in  16  Apple II bus address.
REQ-016 a2_data  in  8  Apple II bus data.
REQ-017 irq  out  1  level interrupt to PicoSoC, registered.

Function
REQ-018 A request SHALL be accepted when iomem_valid=1 and iomem_ready=0; iomem_ready SHALL be 1 in exactly the next cycle, then 0; one pop maximum per request.
REQ-019 iomem_rdata SHALL be 0 except in the ready cycle of a read; unmapped reads return 0; unmapped writes ignored.
REQ-020 Register map (addr[4:2]): 0 KEY_DATA (R), 1 CMD_DATA (R), 2 STATUS (R / W1C), 3 IRQ_EN (R/W), 4 FLUSH (W, reads 0).
REQ-021 KEY_DATA/CMD_DATA read SHALL return {23'b0, valid, data[7:0]} and pop the head when non-empty; when empty returns 0, no pop.
REQ-022 STATUS read: bit0 key non-empty, bit1 cmd non-empty, bit2 key_ovf, bit3 cmd_ovf, [15:8] key count, [23:16] cmd count, others 0.
REQ-023 STATUS write: wdata bit2/bit3 =1 SHALL clear key_ovf/cmd_ovf; other bits ignored.
REQ-024 IRQ_EN [1:0] enable non-empty irq for key/cmd, [2] enables overflow irq; read returns {29'b0, irq_en}.
REQ-025 FLUSH write: bit0 empties key FIFO, bit1 empties cmd FIFO (pointers and count to 0, ovf unchanged).
REQ-026 Key push on key_strobe=1; cmd push on a2_wr_strobe=1 and a2_addr==CMD_ADDR; 8 bits stored unmodified.
REQ-027 Push while full and no simultaneous pop: data dropped, matching ovf sticky bit set; FIFO contents unchanged.
REQ-028 Push and pop in same cycle on a full FIFO: both occur, count unchanged, no overflow.
REQ-029 Push and pop in same cycle on an empty FIFO: read returns valid=0, push completes, count becomes 1.
REQ-030 Flush and push in same cycle: flush wins, push discarded, no ovf.
REQ-031 Overflow and W1C clear in same cycle: set wins.
REQ-032 Pointers SHALL wrap modulo depth; count width $clog2(DEPTH)+1, range 0..DEPTH.
REQ-033 irq next cycle = (en[0]&key_ne)|(en[1]&cmd_ne)|(en[2]&(key_ovf|cmd_ovf)).
REQ-034 Pushed data SHALL be readable by a request accepted in the cycle after the push.

Reset
REQ-035 resetn=0 SHALL asynchronously clear iomem_ready, iomem_rdata, irq, irq_en, both ovf bits, all pointers and counts; FIFO storage need not be cleared.
REQ-036 Reset mid-request SHALL abort it; no ready pulse issued for that request after deassertion.

Verification
REQ-037 Keys 0x41,0x42 strobed; read KEY_DATA x3 -> 0x141, 0x142, 0x000; STATUS bit0=0.
REQ-038 17 keys into KEY_DEPTH=16 -> STATUS key count 16, bit2=1; write STATUS 0x4 -> bit2=0; 16 reads return keys 1..16 in order.
REQ-039 a2 write 0x55 to 0xC7FF and 0x66 to 0xC7FE -> CMD_DATA reads 0x155 then 0x000.
REQ-040 IRQ_EN=1, key strobe -> irq=1 two cycles after strobe; KEY_DATA read empties FIFO -> irq=0 cycle after ready.
REQ-041 Full key FIFO, key strobe coincident with KEY_DATA pop -> no ovf, count 16, new key last out.
REQ-042 iomem_valid held high for 2 cycles on KEY_DATA read -> exactly one ready pulse, one pop.
